quotient_serializer: RTL and testbench

QUOTIENT_SERIALIZER -- requirements
Module: quotient_serializer

---
 rtl/quotient_serializer.sv | 109 ++++++++++
 tb/tb_quotient_serializer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/quotient_serializer.sv
// Captures a 400-bit divider quotient and streams it MSB byte first over a valid/ready port.
// Optionally suppresses leading zero bytes; the final byte is always sent.
module quotient_serializer #(
    parameter int unsigned SKIP_ZEROS = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [399:0] quotient,
    input  logic         out_ready,
    output logic [7:0]   out_data,
    output logic         out_valid,
    output logic         out_last,
    output logic         busy,
    output logic         overrun
);

    localparam int unsigned NumBytes = 50;
    localparam logic [5:0]  LastIdx  = 6'd49;

    typedef enum logic [1:0] {
        StIdle,
        StSkip,
        StSend
    } state_e;

    state_e         state_q, state_d;
    logic [5:0]     idx_q, idx_d;
    logic [399:0]   shadow_q, shadow_d;
    logic           overrun_q, overrun_d;
    logic [7:0]     cur_byte;
    logic           is_last;

    // Byte 0 sits in the top bits of the shadow register.
    always_comb begin
        cur_byte = 8'h00;
        for (int i = 0; i < NumBytes; i++) begin
            if (idx_q == 6'(i)) begin
                cur_byte = shadow_q[399 - 8 * i -: 8];
            end
        end
    end

    assign is_last = (idx_q == LastIdx);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        overrun_d = overrun_q;

        unique case (state_q)
            StIdle: begin
                if (load) begin
                    shadow_d = quotient;
                    idx_d    = 6'd0;
                    state_d  = (SKIP_ZEROS != 0) ? StSkip : StSend;
                end
            end
            StSkip: begin
                if ((cur_byte == 8'h00) && !is_last) begin
                    idx_d = idx_q + 6'd1;
                end else begin
                    state_d = StSend;
                end
            end
            StSend: begin
                if (out_ready) begin
                    if (is_last) begin
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Any load outside IDLE is dropped, including on the final transfer cycle.
        if (load && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            idx_q     <= 6'd0;
            shadow_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        out_valid = (state_q == StSend);
        out_data  = out_valid ? cur_byte : 8'h00;
        out_last  = out_valid && is_last;
        busy      = (state_q != StIdle);
        overrun   = overrun_q;
    end

endmodule

// File: tb/tb_quotient_serializer.sv
// Directed bench for quotient_serializer: one instance without and one with zero skipping.
module tb_quotient_serializer;

    logic         clk = 1'b0;
    logic         rst;
    logic [399:0] quotient;
    logic         ld, rdy, sel;

    logic         load0, load1, ready0, ready1;
    logic [7:0]   data0, data1;
    logic         valid0, valid1, last0, last1, busy0, busy1, ovr0, ovr1;

    logic [7:0]   o_data;
    logic         o_valid, o_last, o_busy, o_ovr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    quotient_serializer #(.SKIP_ZEROS(0)) u_dut0 (
        .clk(clk), .rst(rst), .load(load0), .quotient(quotient), .out_ready(ready0),
        .out_data(data0), .out_valid(valid0), .out_last(last0), .busy(busy0), .overrun(ovr0)
    );

    quotient_serializer #(.SKIP_ZEROS(1)) u_dut1 (
        .clk(clk), .rst(rst), .load(load1), .quotient(quotient), .out_ready(ready1),
        .out_data(data1), .out_valid(valid1), .out_last(last1), .busy(busy1), .overrun(ovr1)
    );

    always_comb begin
        load0   = sel ? 1'b0 : ld;
        load1   = sel ? ld : 1'b0;
        ready0  = sel ? 1'b0 : rdy;
        ready1  = sel ? rdy : 1'b0;
        o_data  = sel ? data1 : data0;
        o_valid = sel ? valid1 : valid0;
        o_last  = sel ? last1 : last0;
        o_busy  = sel ? busy1 : busy0;
        o_ovr   = sel ? ovr1 : ovr0;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [399:0] q, input int i);
        return q[399 - 8 * i -: 8];
    endfunction

    // Loads q into the selected instance and follows the stream cycle by cycle.
    // exp_first: hand-computed cycle (1 = the cycle right after the load edge) of first valid.
    // exp_start: hand-computed index of the first transmitted byte.
    // stall: randomise out_ready; reload_at: cycle on which a second load is attempted.
    task automatic run_stream(input bit s, input logic [399:0] q, input int exp_first,
                              input int exp_start, input bit stall, input int reload_at);
        int  idx;
        int  first;
        int  xfers;
        bit  done;
        bit  pat [4];
        pat   = '{1'b1, 1'b0, 1'b0, 1'b1};
        idx   = exp_start;
        first = -1;
        xfers = 0;
        done  = 1'b0;
        @(negedge clk);
        sel      = s;
        quotient = q;
        ld       = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 400 && !done; n++) begin
            @(negedge clk);
            ld  = 1'b0;
            rdy = stall ? pat[$urandom_range(0, 3)] : 1'b1;
            if (n == reload_at) begin
                quotient = ~q;
                ld       = 1'b1;
            end
            check_eq("valid", 64'(o_valid), 64'(n >= exp_first));
            if (o_valid) begin
                if (first < 0) first = n;
                check_eq("data", 64'(o_data), 64'(byte_of(q, idx)));
                check_eq("last", 64'(o_last), 64'(idx == 49));
                check_eq("busy_send", 64'(o_busy), 64'd1);
                if (rdy) begin
                    xfers++;
                    if (idx == 49) done = 1'b1;
                    idx++;
                end
            end
        end
        check_eq("timeout", 64'(done), 64'd1);
        check_eq("first_valid", 64'(first), 64'(exp_first));
        check_eq("xfer_count", 64'(xfers), 64'(50 - exp_start));
        @(negedge clk);
        ld  = 1'b0;
        rdy = 1'b0;
        check_eq("idle_valid", 64'(o_valid), 64'd0);
        check_eq("idle_busy", 64'(o_busy), 64'd0);
        check_eq("idle_data", 64'(o_data), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_data0"}, 64'(data0), 64'd0);
        check_eq({tag, "_valid0"}, 64'(valid0), 64'd0);
        check_eq({tag, "_last0"}, 64'(last0), 64'd0);
        check_eq({tag, "_busy0"}, 64'(busy0), 64'd0);
        check_eq({tag, "_ovr0"}, 64'(ovr0), 64'd0);
        check_eq({tag, "_data1"}, 64'(data1), 64'd0);
        check_eq({tag, "_valid1"}, 64'(valid1), 64'd0);
        check_eq({tag, "_busy1"}, 64'(busy1), 64'd0);
        check_eq({tag, "_ovr1"}, 64'(ovr1), 64'd0);
    endtask

    logic [399:0] q_seq, q_ab, q_stall;

    initial begin
        for (int i = 0; i < 50; i++) begin
            q_seq[399 - 8 * i -: 8]   = 8'(i + 1);
            q_stall[399 - 8 * i -: 8] = (i < 3) ? 8'h00 : 8'(8'h40 + i);
        end
        q_ab = 400'hABCD;

        rst = 1'b0; ld = 1'b0; rdy = 1'b0; sel = 1'b0; quotient = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b1;

        run_stream(1'b0, q_seq, 1, 0, 1'b0, 0);      // no skip, 0x01..0x32
        run_stream(1'b1, q_ab, 50, 48, 1'b0, 0);     // 48 leading zero bytes
        run_stream(1'b1, '0, 51, 49, 1'b0, 0);       // all zero: single 0x00, last
        run_stream(1'b1, q_stall, 5, 3, 1'b1, 0);    // stalls with 3 leading zeros
        check_eq("ovr1_clean", 64'(ovr1), 64'd0);

        run_stream(1'b1, q_seq, 2, 0, 1'b0, 10);     // second load mid-stream ignored
        check_eq("ovr1_set", 64'(ovr1), 64'd1);
        check_eq("ovr0_clear", 64'(ovr0), 64'd0);
        run_stream(1'b1, q_ab, 50, 48, 1'b0, 0);
        check_eq("ovr1_sticky", 64'(ovr1), 64'd1);

        run_stream(1'b0, q_seq, 1, 0, 1'b0, 50);     // load on the final transfer cycle
        check_eq("ovr0_final", 64'(ovr0), 64'd1);

        // Reset together with a load in IDLE.
        @(negedge clk);
        sel = 1'b0; quotient = q_seq; ld = 1'b1; rst = 1'b0;
        @(negedge clk);
        ld = 1'b0;
        check_reset_outputs("rst_load");
        rst = 1'b1;

        // Reset during SEND at index 20.
        @(negedge clk);
        sel = 1'b0; quotient = q_seq; ld = 1'b1; rdy = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 21; n++) begin
            @(negedge clk);
            ld = 1'b0;
        end
        check_eq("mid_data", 64'(data0), 64'h15);
        rst = 1'b0;
        @(negedge clk);
        rdy = 1'b0;
        check_reset_outputs("rst_mid");
        rst = 1'b1;
        run_stream(1'b0, q_seq, 1, 0, 1'b0, 0);      // fresh, complete sequence

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
